lap_demux16: RTL and testbench

- Writer side of the stopwatch display path: routes the live 16-bit BCD time (MM:SS, 4 digits) into two registered streams, live and lap-frozen.
- Drives the select line for the downstream 16-bit 2:1 display mux.
- Captures a lap value on a lap button pulse and holds the lap view for a programmable number of seconds.
- Returns automatically to the live view when the hold expires.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/lap_hold_timer.sv | 34 +++
 rtl/lap_demux16.sv | 96 +++++++++
 tb/tb_lap_demux16.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch display path: time value, lap view states, history depth.
package stopwatch_pkg;

    typedef logic [15:0] time_t;

    typedef enum logic {
        LIVE = 1'b0,
        HOLD = 1'b1
    } lap_state_e;

    localparam int HIST_DEPTH = 4;

endpackage

// File: rtl/lap_hold_timer.sv
// Loadable down-counter for the lap view hold; expire pulses on the tick that takes it from 1 to 0.
module lap_hold_timer #(
    parameter int HOLD_S = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    input  logic clr,
    output logic expire
);

    localparam int CW = (HOLD_S < 2) ? 1 : $clog2(HOLD_S + 1);

    logic [CW-1:0] cnt;

    // HOLD_S=0 loads zero, so the counter never reaches the expiry condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(HOLD_S);
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        expire = tick && !load && !clr && (cnt == CW'(1));
    end

endmodule

// File: rtl/lap_demux16.sv
// Stopwatch display writer: live and lap-frozen time streams plus display mux select.
// Optional 4-entry lap history enabled by defining LAP_DEMUX_HIST_EN.
module lap_demux16
    import stopwatch_pkg::*;
#(
    parameter int W      = 16,
    parameter int HOLD_S = 3,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic [W-1:0]     time_in,
    input  logic             lap_pulse,
    input  logic             clr_pulse,
`ifdef LAP_DEMUX_HIST_EN
    input  logic [1:0]       hist_idx,
    output logic [W-1:0]     hist_o,
`endif
    output logic [W-1:0]     run_o,
    output logic [W-1:0]     lap_o,
    output logic             sel_o,
    output logic [CNT_W-1:0] lap_cnt,
    output logic             hold_o
);

    localparam logic [0:0] S_LIVE = 1'(LIVE);
    localparam logic [0:0] S_HOLD = 1'(HOLD);

    logic [0:0] state;
    logic       expire;

    lap_hold_timer #(
        .HOLD_S (HOLD_S)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lap_pulse),
        .tick   (tick_1hz && (state == S_HOLD)),
        .clr    (clr_pulse),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_o   <= '0;
            lap_o   <= '0;
            lap_cnt <= '0;
            state   <= S_LIVE;
        end else begin
            run_o <= time_in;
            if (clr_pulse) begin
                lap_o   <= '0;
                lap_cnt <= '0;
                state   <= S_LIVE;
            end else if (lap_pulse) begin
                lap_o <= time_in;
                if (lap_cnt != '1) begin
                    lap_cnt <= lap_cnt + 1'b1;
                end
                state <= S_HOLD;
            end else if (expire) begin
                state <= S_LIVE;
            end
        end
    end

    assign sel_o  = (state == S_HOLD);
    assign hold_o = (state == S_HOLD);

`ifdef LAP_DEMUX_HIST_EN
    localparam int PW = $clog2(HIST_DEPTH);

    logic [W-1:0]  hist [HIST_DEPTH];
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            wr_ptr <= '0;
        end else if (clr_pulse) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            wr_ptr <= '0;
        end else if (lap_pulse) begin
            hist[wr_ptr] <= time_in;
            wr_ptr       <= wr_ptr + 1'b1;
        end
    end

    // Newest entry sits just behind the write pointer.
    always_comb begin
        hist_o = hist[wr_ptr - PW'(1) - PW'(hist_idx)];
    end
`endif

endmodule

// File: tb/tb_lap_demux16.sv
// Directed self-checking bench for lap_demux16 (default HOLD_S=3, CNT_W=4).
module tb_lap_demux16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1hz;
    logic [15:0] time_in;
    logic        lap_pulse;
    logic        clr_pulse;
    logic [15:0] run_o;
    logic [15:0] lap_o;
    logic        sel_o;
    logic [3:0]  lap_cnt;
    logic        hold_o;
`ifdef LAP_DEMUX_HIST_EN
    logic [1:0]  hist_idx;
    logic [15:0] hist_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lap_demux16 #(
        .W      (16),
        .HOLD_S (3),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .time_in   (time_in),
        .lap_pulse (lap_pulse),
        .clr_pulse (clr_pulse),
`ifdef LAP_DEMUX_HIST_EN
        .hist_idx  (hist_idx),
        .hist_o    (hist_o),
`endif
        .run_o     (run_o),
        .lap_o     (lap_o),
        .sel_o     (sel_o),
        .lap_cnt   (lap_cnt),
        .hold_o    (hold_o)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
        lap_pulse = 1'b0;
        clr_pulse = 1'b0;
        tick_1hz  = 1'b0;
    endtask

    task automatic lap(input logic [15:0] t);
        time_in   = t;
        lap_pulse = 1'b1;
        step();
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; time_in = 16'h0000;
        lap_pulse = 1'b0; clr_pulse = 1'b0;
`ifdef LAP_DEMUX_HIST_EN
        hist_idx = 2'd0;
`endif
        time_in = 16'h0999;
        repeat (2) @(posedge clk);
        #1;
        check("rst_run", run_o, 16'h0000);
        check("rst_lap", lap_o, 16'h0000);
        check("rst_sel", {15'd0, sel_o}, 16'd0);
        check("rst_cnt", {12'd0, lap_cnt}, 16'd0);
        rst_n = 1'b1;
        step();
        check("run_latency", run_o, 16'h0999);

        // Capture and expiry after three ticks
        lap(16'h0145);
        check("cap1_lap", lap_o, 16'h0145);
        check("cap1_sel", {15'd0, sel_o}, 16'd1);
        check("cap1_hold", {15'd0, hold_o}, 16'd1);
        check("cap1_cnt", {12'd0, lap_cnt}, 16'd1);
        tick(); step();
        tick(); step();
        check("tick2_sel", {15'd0, sel_o}, 16'd1);
        tick();
        check("tick3_sel", {15'd0, sel_o}, 16'd0);
        check("tick3_lap", lap_o, 16'h0145);

        // Recapture in HOLD reloads the counter
        lap(16'h0100);
        tick(); tick();
        lap(16'h0210);
        check("recap_lap", lap_o, 16'h0210);
        check("recap_cnt", {12'd0, lap_cnt}, 16'd3);
        tick(); tick();
        check("recap_t2_sel", {15'd0, sel_o}, 16'd1);
        tick();
        check("recap_t3_sel", {15'd0, sel_o}, 16'd0);

        tick();
        check("live_tick_sel", {15'd0, sel_o}, 16'd0);

        // Lap on the expiring tick wins
        lap(16'h0300);
        tick(); tick();
        tick_1hz = 1'b1;
        lap(16'h0301);
        check("laptick_sel", {15'd0, sel_o}, 16'd1);
        check("laptick_lap", lap_o, 16'h0301);
        tick(); tick();
        check("laptick_t2_sel", {15'd0, sel_o}, 16'd1);
        tick();
        check("laptick_t3_sel", {15'd0, sel_o}, 16'd0);
        check("cnt5", {12'd0, lap_cnt}, 16'd5);

        // Clear beats lap
        clr_pulse = 1'b1;
        lap(16'h0400);
        check("clr_cnt", {12'd0, lap_cnt}, 16'd0);
        check("clr_lap", lap_o, 16'h0000);
        check("clr_sel", {15'd0, sel_o}, 16'd0);

        // Clear in HOLD returns to LIVE
        lap(16'h0410);
        clr_pulse = 1'b1;
        step();
        check("clr_hold_sel", {15'd0, sel_o}, 16'd0);
        check("clr_hold_lap", lap_o, 16'h0000);

        // Saturation
        for (int i = 1; i <= 20; i++) lap(16'(i));
        check("sat_cnt", {12'd0, lap_cnt}, 16'd15);
        check("sat_lap", lap_o, 16'h0014);

        // Async reset mid-HOLD
        clr_pulse = 1'b1; step();
        lap(16'h0111);
        lap(16'h0123);
        check("pre_rst_cnt", {12'd0, lap_cnt}, 16'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_lap", lap_o, 16'h0000);
        check("arst_run", run_o, 16'h0000);
        check("arst_sel", {15'd0, sel_o}, 16'd0);
        check("arst_hold", {15'd0, hold_o}, 16'd0);
        check("arst_cnt", {12'd0, lap_cnt}, 16'd0);
        step();
        rst_n = 1'b1;
        time_in = 16'h0555;
        step();
        check("post_rst_sel", {15'd0, sel_o}, 16'd0);
        check("post_rst_run", run_o, 16'h0555);

`ifdef LAP_DEMUX_HIST_EN
        for (int i = 1; i <= 5; i++) lap(16'(i));
        hist_idx = 2'd0; #1 check("hist0", hist_o, 16'h0005);
        hist_idx = 2'd1; #1 check("hist1", hist_o, 16'h0004);
        hist_idx = 2'd2; #1 check("hist2", hist_o, 16'h0003);
        hist_idx = 2'd3; #1 check("hist3", hist_o, 16'h0002);
        clr_pulse = 1'b1; step();
        lap(16'h0777);
        hist_idx = 2'd0; #1 check("hist_new", hist_o, 16'h0777);
        hist_idx = 2'd1; #1 check("hist_unwritten", hist_o, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
